// File: rtl/clkgate_pkg.sv
// Shared definitions for the clock-gate enable controller: state encoding,
// default widths and the wake-settle window sanity check.
package clkgate_pkg;

  // Default widths and settle window.
  localparam int CW_DEF          = 8;
  localparam int SW_DEF          = 16;
  localparam int WAKE_CYCLES_DEF = 2;
  localparam int WAKE_CYCLES_MIN = 1;

  // Controller state encoding.
  typedef logic [1:0] state_t;
  localparam state_t ST_RUN   = 2'd0;
  localparam state_t ST_COUNT = 2'd1;
  localparam state_t ST_GATED = 2'd2;
  localparam state_t ST_WAKE  = 2'd3;

  // A settle window of zero cycles would let ready rise together with en,
  // before the gated domain has seen a single clock.
  function automatic bit wake_cycles_ok(input int n);
    return n >= WAKE_CYCLES_MIN;
  endfunction

endpackage

// File: rtl/clkgate_satcnt.sv
// Generic saturating up-counter with synchronous clear; clear beats increment.
module clkgate_satcnt #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] count
);

  // Count events, hold at all-ones, clear on request.
  always_ff @(posedge clk) begin
    if (reset || clr) begin
      count <= '0;
    end else if (inc && (count != {W{1'b1}})) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/clkgate_ctrl.sv
// Clock-gate enable controller. Counts consecutive idle cycles in the
// ungated domain, drops the gate enable once the programmed threshold is met
// and the downstream logic is drained, and on wake re-enables the clock while
// holding ready low for a fixed settle window.
module clkgate_ctrl
  import clkgate_pkg::*;
#(
  parameter int CW          = CW_DEF,
  parameter int WAKE_CYCLES = WAKE_CYCLES_DEF,
  parameter int SW          = SW_DEF
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          activity,
  input  logic          quiesce,
  input  logic          wake,
  input  logic          force_on,
  input  logic [CW-1:0] idle_thresh,
  output logic          en,
  output logic          ready,
  output logic          gated,
  output logic [SW-1:0] gate_count,
  input  logic          clr_count
);

  if (!wake_cycles_ok(WAKE_CYCLES)) begin : g_wake_cycles_check
    $error("clkgate_ctrl: WAKE_CYCLES must be at least 1");
  end

  localparam int WW = $clog2(WAKE_CYCLES + 1);
  localparam logic [WW-1:0] WAKE_LOAD = WW'(WAKE_CYCLES - 1);

  state_t        state;
  logic [CW-1:0] cnt;
  logic [WW-1:0] wcnt;

  logic          thresh_zero;
  logic          idle_ok;
  logic          wake_ev;
  logic [CW:0]   cnt_next;
  logic          thresh_hit;
  logic          gate_entry;

  assign thresh_zero = (idle_thresh == '0);
  assign idle_ok     = !activity && quiesce && !force_on && !thresh_zero;
  assign wake_ev     = activity || wake || force_on || thresh_zero;

  // One bit wider so a counter sitting at all-ones cannot wrap past the
  // threshold; the threshold is compared live so lowering it takes effect at
  // the next idle sample.
  assign cnt_next   = {1'b0, cnt} + 1'b1;
  assign thresh_hit = (cnt_next >= {1'b0, idle_thresh});

  // Cycle on which the controller commits to gating; also the event counted.
  // idle_ok already excludes force_on, so forcing the clock on always blocks it.
  always_comb begin
    gate_entry = 1'b0;
    case (state)
      ST_RUN:   gate_entry = idle_ok && (idle_thresh == CW'(1));
      ST_COUNT: gate_entry = idle_ok && thresh_hit;
      default:  gate_entry = 1'b0;
    endcase
  end

  // Main FSM; en/ready/gated are registered alongside the state so the
  // clock-gate cell never sees a combinational path from the inputs.
  // NOTE: all state here is updated with non-blocking assignments so every
  // register samples pre-edge values; the reset is synchronous because clk is
  // never gated, so reset still takes effect while the downstream clock is off.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_RUN;
      cnt   <= '0;
      wcnt  <= '0;
      en    <= 1'b1;
      ready <= 1'b1;
      gated <= 1'b0;
    end else begin
      case (state)
        ST_RUN: begin
          if (gate_entry) begin
            state <= ST_GATED;
            cnt   <= '0;
            en    <= 1'b0;
            ready <= 1'b0;
            gated <= 1'b1;
          end else if (idle_ok) begin
            state <= ST_COUNT;
            cnt   <= CW'(1);
          end
        end

        ST_COUNT: begin
          if (!idle_ok) begin
            state <= ST_RUN;
            cnt   <= '0;
          end else if (gate_entry) begin
            state <= ST_GATED;
            cnt   <= '0;
            en    <= 1'b0;
            ready <= 1'b0;
            gated <= 1'b1;
          end else begin
            cnt <= cnt_next[CW-1:0];
          end
        end

        // Loss of quiesce is ignored here; only a wake event reopens the clock.
        ST_GATED: begin
          if (wake_ev) begin
            state <= ST_WAKE;
            wcnt  <= WAKE_LOAD;
            en    <= 1'b1;
            gated <= 1'b0;
          end
        end

        // Settle window: clock running, ready held low, all inputs ignored.
        ST_WAKE: begin
          if (wcnt == '0) begin
            state <= ST_RUN;
            ready <= 1'b1;
          end else begin
            wcnt <= wcnt - 1'b1;
          end
        end

        default: begin
          state <= ST_RUN;
          cnt   <= '0;
          wcnt  <= '0;
          en    <= 1'b1;
          ready <= 1'b1;
          gated <= 1'b0;
        end
      endcase
    end
  end

  clkgate_satcnt #(
    .W (SW)
  ) u_gate_count (
    .clk   (clk),
    .reset (reset),
    .inc   (gate_entry),
    .clr   (clr_count),
    .count (gate_count)
  );

endmodule

// File: tb/tb_clkgate_ctrl.sv
// Directed self-checking bench for clkgate_ctrl. A second instance with a
// 2-bit event counter shares all stimulus to exercise saturation.
module tb_clkgate_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        activity;
  logic        quiesce;
  logic        wake;
  logic        force_on;
  logic [7:0]  idle_thresh;
  logic        clr_count;

  logic        en, ready, gated;
  logic [15:0] gate_count;
  logic        en_s, ready_s, gated_s;
  logic [1:0]  gate_count_s;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  clkgate_ctrl #(.CW(8), .WAKE_CYCLES(2), .SW(16)) dut (
    .clk         (clk),
    .reset       (reset),
    .activity    (activity),
    .quiesce     (quiesce),
    .wake        (wake),
    .force_on    (force_on),
    .idle_thresh (idle_thresh),
    .en          (en),
    .ready       (ready),
    .gated       (gated),
    .gate_count  (gate_count),
    .clr_count   (clr_count)
  );

  clkgate_ctrl #(.CW(8), .WAKE_CYCLES(2), .SW(2)) dut_s (
    .clk         (clk),
    .reset       (reset),
    .activity    (activity),
    .quiesce     (quiesce),
    .wake        (wake),
    .force_on    (force_on),
    .idle_thresh (idle_thresh),
    .en          (en_s),
    .ready       (ready_s),
    .gated       (gated_s),
    .gate_count  (gate_count_s),
    .clr_count   (clr_count)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Advance n rising edges, then settle 1 time unit past the last edge.
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step(1);
    reset = 1'b0;
  endtask

  initial begin
    reset       = 1'b1;
    activity    = 1'b1;
    quiesce     = 1'b0;
    wake        = 1'b0;
    force_on    = 1'b0;
    idle_thresh = 8'd4;
    clr_count   = 1'b0;
    step(2);
    reset = 1'b0;

    // Reset state.
    check("rst_en",    32'(en),         32'd1);
    check("rst_ready", 32'(ready),      32'd1);
    check("rst_gated", 32'(gated),      32'd0);
    check("rst_count", 32'(gate_count), 32'd0);

    // Threshold 4: three idle samples keep en high, the fourth drops it.
    activity = 1'b0;
    quiesce  = 1'b1;
    step(3);
    check("idle3_en", 32'(en), 32'd1);
    step(1);
    check("idle4_en",    32'(en),         32'd0);
    check("idle4_gated", 32'(gated),      32'd1);
    check("idle4_ready", 32'(ready),      32'd0);
    check("idle4_count", 32'(gate_count), 32'd1);

    // Loss of quiesce while gated is ignored.
    quiesce = 1'b0;
    step(3);
    check("gated_hold_en",    32'(en),    32'd0);
    check("gated_hold_gated", 32'(gated), 32'd1);

    // Wake pulse: en next cycle, ready low for two cycles, then high.
    wake = 1'b1;
    step(1);
    wake = 1'b0;
    check("wake1_en",    32'(en),    32'd1);
    check("wake1_ready", 32'(ready), 32'd0);
    check("wake1_gated", 32'(gated), 32'd0);
    step(1);
    check("wake2_ready", 32'(ready), 32'd0);
    check("wake2_en",    32'(en),    32'd1);
    step(1);
    check("wake3_ready", 32'(ready), 32'd1);

    // Activity pulse inside COUNT restarts the idle count.
    do_reset();
    activity = 1'b0;
    quiesce  = 1'b1;
    step(2);
    activity = 1'b1;
    step(1);
    activity = 1'b0;
    check("pulse_en", 32'(en), 32'd1);
    step(3);
    check("pulse_idle3_en", 32'(en), 32'd1);
    step(1);
    check("pulse_idle4_en",    32'(en),         32'd0);
    check("pulse_idle4_count", 32'(gate_count), 32'd1);

    // force_on held with idle inputs never gates.
    quiesce = 1'b0;
    do_reset();
    force_on = 1'b1;
    quiesce  = 1'b1;
    step(100);
    check("force_en",    32'(en),         32'd1);
    check("force_count", 32'(gate_count), 32'd0);
    force_on = 1'b0;

    // Threshold 0 disables auto-gating.
    idle_thresh = 8'd0;
    step(100);
    check("thr0_en",    32'(en),         32'd1);
    check("thr0_count", 32'(gate_count), 32'd0);

    // force_on inside COUNT returns to RUN; count restarts from scratch.
    idle_thresh = 8'd4;
    step(3);
    force_on = 1'b1;
    step(1);
    force_on = 1'b0;
    step(3);
    check("force_count_en", 32'(en), 32'd1);
    step(1);
    check("force_regate_en", 32'(en), 32'd0);

    // force_on while gated runs the wake sequence.
    force_on = 1'b1;
    step(1);
    check("force_wake_en",    32'(en),    32'd1);
    check("force_wake_ready", 32'(ready), 32'd0);
    step(2);
    check("force_wake_rdy", 32'(ready), 32'd1);
    force_on = 1'b0;
    quiesce  = 1'b0;

    // Long idle without quiesce never gates.
    do_reset();
    step(50);
    check("noq_en", 32'(en), 32'd1);

    // Threshold 1 gates on the first idle sample; reset while gated.
    idle_thresh = 8'd1;
    quiesce     = 1'b1;
    step(1);
    check("thr1_gated", 32'(gated), 32'd1);
    quiesce = 1'b0;
    reset   = 1'b1;
    step(1);
    reset = 1'b0;
    check("rstg_en",    32'(en),         32'd1);
    check("rstg_ready", 32'(ready),      32'd1);
    check("rstg_gated", 32'(gated),      32'd0);
    check("rstg_count", 32'(gate_count), 32'd0);

    // Lowering the threshold below the running count gates at once.
    idle_thresh = 8'd8;
    quiesce     = 1'b1;
    step(5);
    check("lower_pre_en", 32'(en), 32'd1);
    idle_thresh = 8'd3;
    step(1);
    check("lower_gated", 32'(gated), 32'd1);
    quiesce = 1'b0;

    // Five gating events: 16-bit counter reads 5, 2-bit counter saturates at 3.
    do_reset();
    idle_thresh = 8'd1;
    for (int i = 0; i < 5; i++) begin
      quiesce = 1'b1;
      step(1);
      quiesce = 1'b0;
      wake    = 1'b1;
      step(1);
      wake = 1'b0;
      step(2);
    end
    check("sat_count_w16", 32'(gate_count),   32'd5);
    check("sat_count_w2",  32'(gate_count_s), 32'd3);

    // Clear on the same cycle as a gating entry wins.
    quiesce   = 1'b1;
    clr_count = 1'b1;
    step(1);
    clr_count = 1'b0;
    check("clr_gated",     32'(gated),        32'd1);
    check("clr_count_w16", 32'(gate_count),   32'd0);
    check("clr_count_w2",  32'(gate_count_s), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
